// File: rtl/alu_mdu.sv
// RV32IM execute unit: single-cycle integer ALU plus a bit-serial multiply/divide
// engine, with valid/ready handshakes on both the issue and result sides.
module alu_mdu #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic            opb5,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              illegal_q, illegal_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] sh_q, sh_d;
  logic [XLEN-1:0]   mb_q, mb_d;
  logic [2:0]        mop_q, mop_d;
  logic              bsgn_q, bsgn_d;
  logic              fixq_q, fixq_d;
  logic              fixr_q, fixr_d;

  logic              accept;
  logic [SHW-1:0]    shamt;
  logic              is_m_enc, dec_illegal, do_m;
  logic [XLEN-1:0]   alu_res;
  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;

  logic              last;
  logic [XLEN:0]     div_tmp, div_dvs, div_rem;
  logic              div_ge;
  logic [2*XLEN-1:0] step_acc, step_sh;
  logic [XLEN-1:0]   step_mb, rem_mag, m_res;

  assign in_ready  = !flush && (state_q == S_IDLE || (state_q == S_DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign illegal   = illegal_q;
  assign shamt     = src_b[SHW-1:0];

  // Decode and single-cycle datapath
  always_comb begin
    is_m_enc    = opb5 && (funct7 == 7'b0000001);
    dec_illegal = 1'b0;
    do_m        = 1'b0;
    alu_res     = '0;
    if (!ALUOp[1]) begin
      alu_res = ALUOp[0] ? (src_a - src_b) : (src_a + src_b);
    end else begin
      dec_illegal = (opb5 && !(funct7 == 7'b0000000 || funct7 == 7'b0100000 ||
                               funct7 == 7'b0000001)) || (is_m_enc && !ENABLE_M);
      do_m = is_m_enc && ENABLE_M && !dec_illegal;
      case (funct3)
        3'b000: alu_res = (opb5 && funct7[5]) ? (src_a - src_b) : (src_a + src_b);
        3'b001: alu_res = src_a << shamt;
        3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
        3'b011: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
        3'b100: alu_res = src_a ^ src_b;
        3'b101: alu_res = funct7[5] ? $unsigned($signed(src_a) >>> shamt) : (src_a >> shamt);
        3'b110: alu_res = src_a | src_b;
        default: alu_res = src_a & src_b;
      endcase
      if (dec_illegal) alu_res = '0;
    end
  end

  // Operand signedness per M variant; divide runs on magnitudes
  always_comb begin
    a_sgn = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
    b_sgn = funct3[2] ? !funct3[0] : !funct3[1];
    a_neg = a_sgn && src_a[XLEN-1];
    b_neg = b_sgn && src_b[XLEN-1];
    a_mag = a_neg ? -src_a : src_a;
    b_mag = b_neg ? -src_b : src_b;
  end

  // One iteration of the serial engine
  always_comb begin
    last     = (cnt_q == CW'(1));
    div_tmp  = {acc_q[XLEN-1:0], mb_q[XLEN-1]};
    div_dvs  = {1'b0, sh_q[XLEN-1:0]};
    div_ge   = (div_tmp >= div_dvs);
    div_rem  = div_ge ? (div_tmp - div_dvs) : div_tmp;
    step_acc = acc_q;
    step_sh  = sh_q;
    step_mb  = mb_q;
    if (mop_q[2]) begin
      step_acc = {{(XLEN-1){1'b0}}, div_rem};
      step_mb  = {mb_q[XLEN-2:0], div_ge};
    end else begin
      // The multiplier MSB carries negative weight when the operand is signed.
      if (mb_q[0]) step_acc = (last && bsgn_q) ? (acc_q - sh_q) : (acc_q + sh_q);
      step_sh = sh_q << 1;
      step_mb = mb_q >> 1;
    end
    rem_mag = step_acc[XLEN-1:0];
    case (mop_q)
      3'b000:                 m_res = step_acc[XLEN-1:0];
      3'b001, 3'b010, 3'b011: m_res = step_acc[2*XLEN-1:XLEN];
      3'b100, 3'b101:         m_res = fixq_q ? -step_mb : step_mb;
      default:                m_res = fixr_q ? -rem_mag : rem_mag;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    mb_d      = mb_q;
    mop_d     = mop_q;
    bsgn_d    = bsgn_q;
    fixq_d    = fixq_q;
    fixr_d    = fixr_q;
    case (state_q)
      S_IDLE: ;
      S_ITER: begin
        acc_d = step_acc;
        sh_d  = step_sh;
        mb_d  = step_mb;
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          state_d   = S_DONE;
          result_d  = m_res;
          illegal_d = 1'b0;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      if (do_m) begin
        state_d = S_ITER;
        cnt_d   = CW'(XLEN);
        acc_d   = '0;
        mop_d   = funct3;
        bsgn_d  = b_sgn;
        // Divide-by-zero keeps the all-ones quotient regardless of dividend sign.
        fixq_d  = (a_neg ^ b_neg) && (src_b != '0);
        fixr_d  = a_neg;
        if (funct3[2]) begin
          sh_d = {{XLEN{1'b0}}, b_mag};
          mb_d = a_mag;
        end else begin
          sh_d = {{XLEN{a_neg}}, src_a};
          mb_d = src_b;
        end
      end else begin
        state_d   = S_DONE;
        result_d  = alu_res;
        illegal_d = dec_illegal;
      end
    end
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
      acc_q     <= '0;
      sh_q      <= '0;
      mb_q      <= '0;
      mop_q     <= '0;
      bsgn_q    <= 1'b0;
      fixq_q    <= 1'b0;
      fixr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      mb_q      <= mb_d;
      mop_q     <= mop_d;
      bsgn_q    <= bsgn_d;
      fixq_q    <= fixq_d;
      fixr_q    <= fixr_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: arithmetic reference model with an expected-result
// queue checked every cycle, plus literal expectations for each directed vector.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, nm_in_valid, out_ready, opb5;
  logic [1:0]  ALUOp;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] src_a, src_b;
  logic        in_ready, out_valid, illegal;
  logic [31:0] result;
  logic        nm_in_ready, nm_out_valid, nm_illegal;
  logic [31:0] nm_result;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mdu #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .opb5(opb5), .funct3(funct3), .funct7(funct7),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .illegal(illegal));

  alu_mdu #(.XLEN(32), .ENABLE_M(1'b0)) dut_nm (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
    .ALUOp(ALUOp), .opb5(opb5), .funct3(funct3), .funct7(funct7),
    .src_a(src_a), .src_b(src_b), .out_valid(nm_out_valid), .out_ready(out_ready),
    .result(nm_result), .illegal(nm_illegal));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: {illegal, result} straight from the RV32IM rules
  function automatic logic [32:0] model(input logic [1:0] op, input logic o5,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input bit enm);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    logic ill;
    bit   is_m, ovf;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ill = 1'b0;
    r   = '0;
    p   = '0;
    if (op == 2'b00) r = a + b;
    else if (op == 2'b01) r = a - b;
    else begin
      is_m = o5 && (f7 == 7'h01);
      if (o5 && !(f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01)) ill = 1'b1;
      if (is_m && !enm) ill = 1'b1;
      if (ill) r = '0;
      else if (is_m) begin
        case (f3)
          3'd0: begin p = sa * sb; r = p[31:0]; end
          3'd1: begin p = sa * sb; r = p[63:32]; end
          3'd2: begin p = sa * ub; r = p[63:32]; end
          3'd3: begin p = ua * ub; r = p[63:32]; end
          3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
          3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
          3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
          default: r = (b == 0) ? a : a % b;
        endcase
      end else begin
        case (f3)
          3'd0: r = (o5 && f7[5]) ? a - b : a + b;
          3'd1: r = a << b[4:0];
          3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: r = (a < b) ? 32'd1 : 32'd0;
          3'd4: r = a ^ b;
          3'd5: r = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
          3'd6: r = a | b;
          default: r = a & b;
        endcase
      end
    end
    return {ill, r};
  endfunction

  typedef struct {
    logic [31:0] r;
    logic        ill;
    int          due;
  } exp_t;
  exp_t q[$];

  // Every-cycle scoreboard check; M ops are due 33 edges after accept,
  // counting the accept edge, single-cycle ops after the accept edge itself.
  always @(negedge clk) begin
    logic [32:0] m;
    logic exp_rdy;
    exp_t e;
    if (reset) begin
      q.delete();
    end else begin
      if (q.size() == 0) chk("idle_out_valid", out_valid, 0);
      else if (cyc < q[0].due) chk("busy_out_valid", out_valid, 0);
      else begin
        chk("sb_out_valid", out_valid, 1);
        chk("sb_result", result, q[0].r);
        chk("sb_illegal", illegal, q[0].ill);
      end
      exp_rdy = !flush && (q.size() == 0 || (cyc >= q[0].due && out_ready));
      chk("sb_in_ready", in_ready, exp_rdy);
      if (flush) q.delete();
      else begin
        if (q.size() > 0 && cyc >= q[0].due && out_ready) void'(q.pop_front());
        if (in_valid && exp_rdy) begin
          m = model(ALUOp, opb5, funct3, funct7, src_a, src_b, 1'b1);
          e.r   = m[31:0];
          e.ill = m[32];
          e.due = cyc + ((ALUOp[1] && opb5 && funct7 == 7'h01) ? 33 : 1);
          q.push_back(e);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic o5, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    ALUOp = op; opb5 = o5; funct3 = f3; funct7 = f7; src_a = a; src_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678;
  endtask

  task automatic get(input string nm, input logic [31:0] er, input logic ei, output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    chk({nm, "_valid"}, out_valid, 1);
    chk(nm, result, er);
    chk({nm, "_ill"}, illegal, ei);
    @(posedge clk); #1;
  endtask

  task automatic vec(input string nm, input logic [1:0] op, input logic o5, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic ei);
    int lat;
    bit m_op;
    m_op = op[1] && o5 && (f7 == 7'h01);
    send(op, o5, f3, f7, a, b);
    get(nm, er, ei, lat);
    chk({nm, "_lat"}, lat, m_op ? 33 : 1);
  endtask

  initial begin
    #400000;
    n_tests++; n_fail++;
    $display("FAIL watchdog: bench did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int lat;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; nm_in_valid = 1'b0; out_ready = 1'b1;
    ALUOp = 2'b00; opb5 = 1'b0; funct3 = 3'd0; funct7 = 7'd0; src_a = 32'd1; src_b = 32'd1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", result, 32'd0);
    chk("rst_illegal", illegal, 0);
    @(posedge clk); #1;

    vec("sub",       2'b10, 1'b1, 3'b000, 7'h20, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0);
    vec("sra",       2'b10, 1'b1, 3'b101, 7'h20, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0);
    vec("sltu",      2'b10, 1'b1, 3'b011, 7'h00, 32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0);
    vec("mulh",      2'b10, 1'b1, 3'b001, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1'b0);
    vec("mulhu",     2'b10, 1'b1, 3'b011, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    vec("div_z",     2'b10, 1'b1, 3'b100, 7'h01, 32'd7,         32'd0,         32'hFFFF_FFFF, 1'b0);
    vec("rem_z",     2'b10, 1'b1, 3'b110, 7'h01, 32'd7,         32'd0,         32'd7,         1'b0);
    vec("div_ovf",   2'b10, 1'b1, 3'b100, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    vec("rem_ovf",   2'b10, 1'b1, 3'b110, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0);
    vec("div_neg",   2'b10, 1'b1, 3'b100, 7'h01, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
    vec("rem_neg",   2'b10, 1'b1, 3'b110, 7'h01, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
    vec("div_negz",  2'b10, 1'b1, 3'b100, 7'h01, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFFF, 1'b0);
    vec("rem_negz",  2'b10, 1'b1, 3'b110, 7'h01, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 1'b0);
    vec("mul",       2'b10, 1'b1, 3'b000, 7'h01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 1'b0);
    vec("mulhsu",    2'b10, 1'b1, 3'b010, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    vec("divu",      2'b10, 1'b1, 3'b101, 7'h01, 32'd100,       32'd7,         32'd14,        1'b0);
    vec("remu",      2'b10, 1'b1, 3'b111, 7'h01, 32'd100,       32'd7,         32'd2,         1'b0);
    vec("divu_z",    2'b10, 1'b1, 3'b101, 7'h01, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0);
    vec("remu_z",    2'b10, 1'b1, 3'b111, 7'h01, 32'd5,         32'd0,         32'd5,         1'b0);
    vec("sll",       2'b10, 1'b1, 3'b001, 7'h00, 32'd1,         32'd35,        32'd8,         1'b0);
    vec("slt",       2'b10, 1'b1, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0);
    vec("srl",       2'b10, 1'b1, 3'b101, 7'h00, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0);
    vec("srai",      2'b10, 1'b0, 3'b101, 7'h20, 32'h8000_0010, 32'h0000_0404, 32'hF800_0001, 1'b0);
    vec("addi_f7",   2'b10, 1'b0, 3'b000, 7'h20, 32'd5,         32'd7,         32'd12,        1'b0);
    vec("xor",       2'b10, 1'b1, 3'b100, 7'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0);
    vec("or",        2'b10, 1'b1, 3'b110, 7'h00, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0);
    vec("and",       2'b10, 1'b1, 3'b111, 7'h00, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h3030_3030, 1'b0);
    vec("add_op00",  2'b00, 1'b1, 3'b111, 7'h7F, 32'd2,         32'd3,         32'd5,         1'b0);
    vec("sub_op01",  2'b01, 1'b1, 3'b000, 7'h7F, 32'd2,         32'd3,         32'hFFFF_FFFF, 1'b0);
    vec("illegal",   2'b10, 1'b1, 3'b000, 7'h02, 32'd5,         32'd7,         32'd0,         1'b1);
    vec("ori_f7",    2'b10, 1'b0, 3'b110, 7'h02, 32'd5,         32'd7,         32'd7,         1'b0);

    // Result held under back-pressure, then consumed with a new op taken on the same edge
    send(2'b00, 1'b0, 3'd0, 7'd0, 32'd3, 32'd4);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, 32'd7);
      chk("hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b00, 1'b0, 3'd0, 7'd0, 32'd10, 32'd20);
    get("b2b_add", 32'd30, 1'b0, lat);
    chk("b2b_lat", lat, 1);

    // Flush on the tenth iteration edge of a divu
    send(2'b10, 1'b1, 3'b101, 7'h01, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    repeat (40) @(posedge clk);
    #1;
    vec("post_flush_add", 2'b00, 1'b0, 3'd0, 7'd0, 32'd20, 32'd22, 32'd42, 1'b0);

    // M encoding on the instance built without the multiply/divide engine
    ALUOp = 2'b10; opb5 = 1'b1; funct3 = 3'b000; funct7 = 7'h01;
    src_a = 32'd6; src_b = 32'd7; nm_in_valid = 1'b1;
    @(posedge clk); #1 nm_in_valid = 1'b0;
    @(negedge clk);
    chk("nm_valid", nm_out_valid, 1);
    chk("nm_illegal", nm_illegal, 1);
    chk("nm_result", nm_result, 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of an iteration emits nothing
    send(2'b10, 1'b1, 3'b000, 7'h01, 32'd9, 32'd9);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_iter_valid", out_valid, 0);
    chk("rst_iter_ready", in_ready, 1);
    repeat (40) @(posedge clk);
    #1;
    vec("post_rst_mul", 2'b10, 1'b1, 3'b000, 7'h01, 32'd9, 32'd9, 32'd81, 1'b0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised execute unit for the RV32IM core: decodes ALUOp/funct3/funct7 and produces the result, not just a control code.
- Single-cycle integer ops complete in one registered cycle.
- M-extension multiply/divide runs iteratively, one bit per cycle.
- Sits between decode and writeback and uses a valid/ready handshake on both sides so the control FSM can stall on it.

Parameters:
- XLEN, 32: operand/result width (8..64).
- ENABLE_M, 1: 1 = execute M ops; 0 = M encodings flagged illegal.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  abort in-flight op (pipeline redirect)
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept
- ALUOp  in  2  00 add, 01 sub, 10/11 decode funct fields
- opb5  in  1  op[5]; 1 = R-type
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7
- src_a  in  XLEN  operand A (rs1)
- src_b  in  XLEN  operand B (rs2 or immediate)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  operation result
- illegal  out  1  valid with out_valid; encoding unsupported

Behaviour:
- Reset (synchronous, active-high, clk edge):
  - state = IDLE; in_ready = 1; out_valid = 0; result = 0; illegal = 0; iteration counter = 0.
- Accept: an op is accepted on any edge where in_valid & in_ready.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Back-to-back acceptance in the same cycle a result is consumed is required.
- Decode (ALUOp 10/11):
  - M-op when opb5 & funct7==0000001. Otherwise funct7[5] selects sub (funct3 000, R-type only) and sra/srai (funct3 101).
  - funct3 map: 000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and.
  - Shift amount = src_b[log2(XLEN)-1:0].
  - slt/sltu results are zero-extended 0/1.
- Illegal: R-type with funct7 not in {0000000, 0100000, 0000001}, or an M-op with ENABLE_M=0. The op completes single-cycle with result = 0 and illegal = 1.
- States: IDLE, ITER, DONE.
  - Single-cycle op: accept -> DONE. Result registered; out_valid high after the accept edge (latency 1).
  - M-op: accept -> ITER. Counter loads XLEN and runs exactly XLEN iteration edges.
    - mul*: operands are sign/zero-extended per variant (mul/mulh signed×signed, mulhsu signed×unsigned, mulhu unsigned×unsigned), then shift-add over 2·XLEN bits.
    - div*: restoring division on magnitudes, signs fixed on exit.
    - ITER -> DONE on the edge the counter reaches 0. out_valid rises exactly XLEN+1 edges after accept.
  - mul returns the low XLEN bits; mulh/mulhsu/mulhu return the high XLEN bits.
  - DONE: result/illegal held stable while out_valid & !out_ready. With out_ready, go to IDLE, or take the next op if one is offered the same edge.
- Division corner cases, fixed by RISC-V and not trapped:
  - divide by zero: div/divu quotient = all ones; rem/remu = src_a.
  - signed overflow (src_a = -2^(XLEN-1), src_b = -1): div quotient = src_a; rem = 0.
  - Corner cases take the full XLEN+1 latency (uniform timing).
- ALUOp 00/01: add/sub regardless of funct fields; never illegal.
- Flush: takes priority over accept and completion. Next edge: state = IDLE, out_valid = 0, counter = 0. An op offered with flush is not accepted.
- Reset mid-ITER: same as flush; nothing is emitted.
- Operands are captured at accept. src_a/src_b changes during ITER have no effect.

Test Plan:
- Reset with in_valid=1: out_valid=0, in_ready=1, result=0 in the cycle after reset deasserts.
- ALUOp=10, opb5=1, funct7=0100000, funct3=000, a=5, b=7: result=0xFFFFFFFE one cycle later. With funct3=101, a=0x80000000, b=4: result=0xF8000000 (sra). With funct3=011, a=1, b=0xFFFFFFFF: result=1 (sltu).
- mulh, a=0xFFFFFFFF, b=0xFFFFFFFF: out_valid exactly 33 edges after accept, result=0. mulhu on the same operands: result=0xFFFFFFFE.
- div a=7, b=0: quotient 0xFFFFFFFF. rem a=7, b=0: 7. div a=0x80000000, b=0xFFFFFFFF: 0x80000000. rem on the same operands: 0. div a=-7, b=2: 0xFFFFFFFD. rem a=-7, b=2: 0xFFFFFFFF.
- Hold out_ready=0 for 5 cycles after a result: result stable, in_ready=0. Then out_ready=1 with a new add offered: accepted on the same edge; its result is valid on the next cycle.
- Flush asserted at iteration 10 of a divu: out_valid stays 0 and in_ready=1 next cycle. A following add completes correctly. funct7=0000010: illegal=1, result=0. ENABLE_M=0 with mul: illegal=1.
